// File: rtl/ladybird_boot_sequencer_pkg.sv
// Shared types and constants for the ladybird boot sequencer.
package ladybird_boot_pkg;

  typedef enum logic [2:0] {
    HOLD,
    IDLE,
    CONF,
    COPY_RD,
    COPY_WR,
    COPY_B,
    RESUME,
    DONE
  } boot_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY         = 2'b00;
  localparam logic [31:0] DEFAULT_CONF_PTR_ADDR = 32'h0000_100c;

endpackage

// File: rtl/ladybird_boot_sequencer_if.sv
// Single-beat AXI write channel bundle (AW, W, B) used by the boot sequencer.
interface ladybird_boot_sequencer_if #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ladybird_boot_sequencer_rtc_prescaler.sv
// 64-bit real-time counter advancing once every RTC_DIV clock cycles.
module ladybird_rtc_prescaler #(
  parameter int unsigned RTC_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] rtc
);
  localparam int unsigned CW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [63:0]   rtc_q, rtc_d;
  logic          wrap;

  always_comb begin
    wrap  = (div_q == CW'(RTC_DIV - 1));
    div_d = wrap ? '0 : div_q + CW'(1);
    rtc_d = wrap ? rtc_q + 64'd1 : rtc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      rtc_q <= '0;
    end else begin
      div_q <= div_d;
      rtc_q <= rtc_d;
    end
  end

  assign rtc = rtc_q;
endmodule

// File: rtl/ladybird_boot_sequencer.sv
// Boot controller: holds cores in reset, writes the config pointer, copies the
// program image over AXI one word at a time, then resumes the enabled harts.
module ladybird_boot_sequencer
  import ladybird_boot_pkg::*;
#(
  parameter int unsigned N_HARTS           = 1,
  parameter int unsigned XLEN              = 32,
  parameter int unsigned AXI_DATA_W        = 32,
  parameter int unsigned AXI_ADDR_W        = 32,
  parameter int unsigned RESET_HOLD_CYCLES = 10,
  parameter int unsigned RTC_DIV           = 100,
  parameter logic [AXI_ADDR_W-1:0] CONF_PTR_ADDR = AXI_ADDR_W'(DEFAULT_CONF_PTR_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [XLEN-1:0]        img_src,
  input  logic [AXI_ADDR_W-1:0]  img_dst,
  input  logic [XLEN-1:0]        img_words,
  input  logic [AXI_ADDR_W-1:0]  conf_ptr,
  input  logic [XLEN-1:0]        entry_pc,
  input  logic [N_HARTS-1:0]     hart_en,
  output logic                   src_rd_en,
  output logic [XLEN-1:0]        src_rd_addr,
  input  logic [AXI_DATA_W-1:0]  src_rd_data,
  ladybird_boot_sequencer_if.master axi,
  output logic                   core_nrst,
  output logic [N_HARTS-1:0]     resume_req,
  output logic [XLEN-1:0]        resume_pc,
  input  logic [N_HARTS-1:0]     halt,
  output logic [63:0]            rtc,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int unsigned HCW = $clog2(RESET_HOLD_CYCLES + 1);

  boot_state_e           state_q, state_d;
  logic [HCW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                  core_nrst_q, core_nrst_d;
  logic                  src_rd_en_q, src_rd_en_d;
  logic [XLEN-1:0]       src_rd_addr_q, src_rd_addr_d;
  logic [AXI_ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [XLEN-1:0]       words_left_q, words_left_d;
  logic                  conf_q, conf_d;
  logic [N_HARTS-1:0]    hart_en_q, hart_en_d;
  logic                  awvalid_q, awvalid_d;
  logic [AXI_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic                  wvalid_q, wvalid_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic                  bready_q, bready_d;
  logic [N_HARTS-1:0]    resume_req_q, resume_req_d;
  logic [XLEN-1:0]       resume_pc_q, resume_pc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    core_nrst_d   = core_nrst_q;
    src_rd_en_d   = 1'b0;
    src_rd_addr_d = src_rd_addr_q;
    dst_addr_d    = dst_addr_q;
    words_left_d  = words_left_q;
    conf_d        = conf_q;
    hart_en_d     = hart_en_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    bready_d      = bready_q;
    resume_req_d  = resume_req_q;
    resume_pc_d   = resume_pc_q;
    err_d         = err_q;

    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == HCW'(RESET_HOLD_CYCLES - 1)) begin
          core_nrst_d = 1'b1;
          state_d     = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      IDLE: begin
        if (start) begin
          src_rd_addr_d = img_src;
          dst_addr_d    = img_dst;
          words_left_d  = img_words;
          hart_en_d     = hart_en;
          resume_pc_d   = entry_pc;
          err_d         = 1'b0;
          conf_d        = 1'b1;
          awvalid_d     = 1'b1;
          awaddr_d      = CONF_PTR_ADDR;
          wvalid_d      = 1'b1;
          wdata_d       = AXI_DATA_W'(conf_ptr);
          state_d       = CONF;
        end
      end
      // The config write and image writes share one AW/W engine; conf_q tells
      // COPY_B which of the two just completed.
      CONF, COPY_WR: begin
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = COPY_B;
        end
      end
      COPY_B: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          if (axi.bresp != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (conf_q) begin
            conf_d = 1'b0;
            if (words_left_q == '0) begin
              resume_req_d = hart_en_q & halt;
              state_d      = RESUME;
            end else begin
              src_rd_en_d = 1'b1;
              state_d     = COPY_RD;
            end
          end else begin
            words_left_d  = words_left_q - XLEN'(1);
            src_rd_addr_d = src_rd_addr_q + XLEN'(1);
            dst_addr_d    = dst_addr_q + AXI_ADDR_W'(4);
            if (words_left_q == XLEN'(1)) begin
              resume_req_d = hart_en_q & halt;
              state_d      = RESUME;
            end else begin
              src_rd_en_d = 1'b1;
              state_d     = COPY_RD;
            end
          end
        end
      end
      // First cycle issues the read strobe; ROM data is valid on the second.
      COPY_RD: begin
        if (!src_rd_en_q) begin
          wdata_d   = src_rd_data;
          awaddr_d  = dst_addr_q;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = COPY_WR;
        end
      end
      RESUME: begin
        resume_req_d = resume_req_q & halt;
        if (resume_req_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = HOLD;
    endcase

    busy_d = !(state_d inside {IDLE, DONE});
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      core_nrst_q   <= 1'b0;
      src_rd_en_q   <= 1'b0;
      src_rd_addr_q <= '0;
      dst_addr_q    <= '0;
      words_left_q  <= '0;
      conf_q        <= 1'b0;
      hart_en_q     <= '0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      bready_q      <= 1'b0;
      resume_req_q  <= '0;
      resume_pc_q   <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      core_nrst_q   <= core_nrst_d;
      src_rd_en_q   <= src_rd_en_d;
      src_rd_addr_q <= src_rd_addr_d;
      dst_addr_q    <= dst_addr_d;
      words_left_q  <= words_left_d;
      conf_q        <= conf_d;
      hart_en_q     <= hart_en_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      bready_q      <= bready_d;
      resume_req_q  <= resume_req_d;
      resume_pc_q   <= resume_pc_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  ladybird_rtc_prescaler #(.RTC_DIV(RTC_DIV)) u_rtc (
    .clk (clk),
    .rst (rst),
    .rtc (rtc)
  );

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = '0;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.bready  = bready_q;
  assign src_rd_en   = src_rd_en_q;
  assign src_rd_addr = src_rd_addr_q;
  assign core_nrst   = core_nrst_q;
  assign resume_req  = resume_req_q;
  assign resume_pc   = resume_pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: doc/ladybird_boot_sequencer.md
Name: ladybird_boot_sequencer

Overview:
Synthesizable boot controller that replaces a simulation-only bring-up flow. It holds the core in reset, then copies a program image word-by-word from a source ROM port into memory over an AXI write master. It also writes the config-string pointer word and releases each enabled hart at a given entry PC. It generates the 64-bit rtc time base from a clock prescaler and sits between the boot ROM, the AXI interconnect and up to N_HARTS ladybird_core instances.

Parameters:
N_HARTS, 1, number of harts driven (resume_req/halt vector width)
XLEN, 32, width of entry PC and addresses
AXI_DATA_W, 32, AXI write data width; one image word = AXI_DATA_W bits
AXI_ADDR_W, 32, AXI address width
RESET_HOLD_CYCLES, 10, cycles core_nrst held low after rst deasserts (>=1)
RTC_DIV, 100, clk cycles per rtc increment (>=1)
CONF_PTR_ADDR, 32'h0000100c, AXI address receiving the config-string pointer word

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins boot; ignored unless state==IDLE
img_src  in  XLEN  word index of first source word
img_dst  in  AXI_ADDR_W  byte address of first destination word (word aligned)
img_words  in  XLEN  number of words to copy (0 allowed)
conf_ptr  in  AXI_ADDR_W  value written to CONF_PTR_ADDR
entry_pc  in  XLEN  resume PC for all harts
hart_en  in  N_HARTS  harts to release
src_rd_en  out  1  source ROM read strobe
src_rd_addr  out  XLEN  source word index
src_rd_data  in  AXI_DATA_W  ROM data, valid exactly 1 cycle after src_rd_en
awvalid/awready/awaddr  out/in/out  1/1/AXI_ADDR_W  AXI AW channel (awprot=0, single beat)
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/AXI_DATA_W/AXI_DATA_W/8  AXI W channel, wstrb all-ones
bvalid/bready/bresp  in/out/in  1/1/2  AXI B channel
core_nrst  out  1  active-low reset to cores
resume_req  out  N_HARTS  per-hart resume request
resume_pc  out  XLEN  registered entry_pc
halt  in  N_HARTS  per-hart halted status
rtc  out  64  real-time counter
busy  out  1  state not IDLE/DONE
done  out  1  one-cycle pulse on completion
err  out  1  sticky until next start; set on bresp!=OKAY

Behaviour:
- Reset values: core_nrst=0, all valids/src_rd_en/resume_req/done/err=0, busy=1, rtc=0, bready=0, state=HOLD.
- HOLD: count RESET_HOLD_CYCLES, then core_nrst=1 (stays 1 until rst) -> IDLE.
- IDLE: start latches img_*, conf_ptr, entry_pc->resume_pc, hart_en -> CONF; err cleared.
- CONF: one AXI write of conf_ptr to CONF_PTR_ADDR -> COPY (or RESUME if img_words==0).
- COPY, per word i: src_rd_en with addr img_src+i; next cycle capture data; issue AW (img_dst+4*i) and W together. Each valid held until its own handshake (independent, any order, same cycle allowed). Then bready=1 until bvalid. At most one outstanding write. Address arithmetic wraps modulo width.
- B response: bresp!=OKAY -> err=1, abort to DONE, no resume. Last word OKAY -> RESUME.
- RESUME: resume_req[h]=1 for each enabled hart with halt[h]=1; each drops the cycle after its halt[h] samples 0. When all enabled harts ack (or hart_en==0) -> DONE.
- DONE: done pulses 1 cycle, busy=0 -> IDLE.
- rtc: prescaler counts 0..RTC_DIV-1; rtc+=1 on wrap; runs whenever rst=0, independent of FSM; 64-bit wrap.
- rst mid-operation: all outputs return to reset values next edge; in-flight AXI transaction abandoned (interconnect shares rst).
- start in any state other than IDLE: ignored, no error.

Decomposition:
- Package ladybird_boot_pkg: FSM state enum (HOLD, IDLE, CONF, COPY_RD, COPY_WR, COPY_B, RESUME, DONE), AXI_RESP_OKAY constant, default CONF_PTR_ADDR.
- Sub-module ladybird_rtc_prescaler (RTC_DIV; clk, rst -> rtc[63:0]).
- The AXI single-write engine stays inline in the FSM.

Test Plan:
- Reset, RESET_HOLD_CYCLES=10 -> core_nrst low exactly 10 cycles after rst drop, busy=1, then IDLE.
- start, img_src=0, img_dst=0x80000000, img_words=4, ROM words 0x11..0x44 -> AXI writes at 0x80000000..0x8000000C, data 0x11..0x44 in order; conf write to 0x100c first; done pulse.
- awready delayed 3 cycles, wready immediate (and reversed) -> W completes first, AW held stable, a single B consumed per word, data intact.
- Word 2 of 4 returns bresp=2'b10 -> err=1, no further AW, resume_req stays 0, done pulses.
- N_HARTS=2, hart_en=2'b11, halt[1] drops 5 cycles after halt[0] -> resume_req[0] drops first, resume_req[1] drops later, resume_pc=entry_pc; done only after both; img_words=0 skips COPY.
- RTC_DIV=4 -> rtc increments every 4 cycles; rst asserted mid-COPY -> rtc=0, valids=0, core_nrst=0 next cycle, HOLD restarts.
